// File: rtl/vram_port_arbiter.sv
// +-----------------------------------------------------------------------------+
// | vram_port_arbiter                                                           |
// | Shares one single-port VRAM between a FIFO-buffered capture write stream    |
// | and a req/ack scanout read port. Optional macro: ARB_STATS_EN adds the      |
// | drop_count and urgent_count statistics outputs.                             |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
`default_nettype none

module vram_port_arbiter #(
    parameter int FIFO_AW      = 3,
    parameter int URGENT_LEVEL = 6,
    parameter int ADDR_W       = 16
) (
    input  logic              vramclk,
    input  logic              rst,
    input  logic              wr_valid,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [1:0]        wr_data,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_ack,
    output logic              rd_valid,
    output logic [1:0]        rd_data,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [1:0]        mem_wdata,
    input  logic [1:0]        mem_rdata,
    output logic [FIFO_AW:0]  fifo_level,
`ifdef ARB_STATS_EN
    output logic [15:0]       drop_count,
    output logic [15:0]       urgent_count,
`endif
    output logic              overflow
);

    localparam int                c_DEPTH   = 2**FIFO_AW;
    localparam logic [FIFO_AW:0]  c_DEPTH_L = (FIFO_AW+1)'(c_DEPTH);

    logic [ADDR_W+1:0]  r_fifo [c_DEPTH];
    logic [FIFO_AW-1:0] r_wr_ptr;
    logic [FIFO_AW-1:0] r_rd_ptr;
    logic [FIFO_AW:0]   r_level;
    logic               r_rd_pend;

    logic              w_level_nz;
    logic              w_urgent;
    logic              w_pop;
    logic              w_rd_grant;
    logic              w_push;
    logic              w_drop;
    logic [ADDR_W+1:0] w_head;

    // Arbitration sees the occupancy before this cycle's push.
    assign w_level_nz = (r_level != '0);
    assign w_urgent   = w_level_nz && (int'(r_level) >= URGENT_LEVEL);
    assign w_pop      = w_level_nz && (w_urgent || !rd_req);
    assign w_rd_grant = !w_urgent && rd_req;
    assign w_push     = wr_valid && ((r_level != c_DEPTH_L) || w_pop);
    assign w_drop     = wr_valid && !w_push;
    assign w_head     = r_fifo[r_rd_ptr];

    assign rd_ack     = w_rd_grant && !rst;
    assign fifo_level = r_level;
    // Read data arrives from the macro in the same cycle rd_valid is raised.
    assign rd_data    = rd_valid ? mem_rdata : 2'b00;

    always_ff @(posedge vramclk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= {wr_addr, wr_data};
        end
    end

    always_ff @(posedge vramclk) begin
        if (rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_level   <= '0;
            r_rd_pend <= 1'b0;
            overflow  <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rd_valid  <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
            if (w_drop) begin
                overflow <= 1'b1;
            end
            mem_en <= w_pop || w_rd_grant;
            mem_we <= w_pop;
            if (w_pop) begin
                mem_addr  <= w_head[ADDR_W+1:2];
                mem_wdata <= w_head[1:0];
            end else if (w_rd_grant) begin
                mem_addr  <= rd_addr;
            end
            r_rd_pend <= w_rd_grant;
            rd_valid  <= r_rd_pend;
        end
    end

`ifdef ARB_STATS_EN
    always_ff @(posedge vramclk) begin
        if (rst) begin
            drop_count   <= '0;
            urgent_count <= '0;
        end else begin
            if (w_drop && (drop_count != 16'hFFFF)) begin
                drop_count <= drop_count + 1'b1;
            end
            if (w_urgent && (urgent_count != 16'hFFFF)) begin
                urgent_count <= urgent_count + 1'b1;
            end
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_vram_port_arbiter.sv
// +-----------------------------------------------------------------------------+
// | tb_vram_port_arbiter                                                        |
// | Bench for vram_port_arbiter: two instances (URGENT_LEVEL 6 and 9) share     |
// | stimulus and are compared against a queue-based reference model.           |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
`default_nettype none

module tb_vram_port_arbiter;

    logic        vramclk = 1'b0;
    logic        rst;
    logic        wr_valid;
    logic [15:0] wr_addr;
    logic [1:0]  wr_data;
    logic        rd_req;
    logic [15:0] rd_addr;
    logic        mem_init;

    logic        ack [2];
    logic        rv  [2];
    logic        men [2];
    logic        mwe [2];
    logic        ovf [2];
    logic [1:0]  rdat [2];
    logic [1:0]  mwd  [2];
    logic [1:0]  mrd  [2];
    logic [15:0] madr [2];
    logic [3:0]  lvl  [2];
`ifdef ARB_STATS_EN
    logic [15:0] dcnt [2];
    logic [15:0] ucnt [2];
`endif

    always #5 vramclk = ~vramclk;

    vram_port_arbiter #(.FIFO_AW(3), .URGENT_LEVEL(6), .ADDR_W(16)) u_dut0 (
        .vramclk(vramclk), .rst(rst), .wr_valid(wr_valid), .wr_addr(wr_addr),
        .wr_data(wr_data), .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(ack[0]),
        .rd_valid(rv[0]), .rd_data(rdat[0]), .mem_en(men[0]), .mem_we(mwe[0]),
        .mem_addr(madr[0]), .mem_wdata(mwd[0]), .mem_rdata(mrd[0]),
        .fifo_level(lvl[0]),
`ifdef ARB_STATS_EN
        .drop_count(dcnt[0]), .urgent_count(ucnt[0]),
`endif
        .overflow(ovf[0])
    );

    vram_port_arbiter #(.FIFO_AW(3), .URGENT_LEVEL(9), .ADDR_W(16)) u_dut1 (
        .vramclk(vramclk), .rst(rst), .wr_valid(wr_valid), .wr_addr(wr_addr),
        .wr_data(wr_data), .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(ack[1]),
        .rd_valid(rv[1]), .rd_data(rdat[1]), .mem_en(men[1]), .mem_we(mwe[1]),
        .mem_addr(madr[1]), .mem_wdata(mwd[1]), .mem_rdata(mrd[1]),
        .fifo_level(lvl[1]),
`ifdef ARB_STATS_EN
        .drop_count(dcnt[1]), .urgent_count(ucnt[1]),
`endif
        .overflow(ovf[1])
    );

    // Behavioural VRAM macros, one per instance (4K words are enough for the bench).
    logic [1:0] vram0 [4096];
    logic [1:0] vram1 [4096];

    function automatic logic [1:0] base(input logic [15:0] a);
        return a[2:1] ^ a[5:4];
    endfunction

    always @(posedge vramclk) begin
        if (mem_init) begin
            for (int i = 0; i < 4096; i++) begin
                vram0[i] <= base(16'(i));
                vram1[i] <= base(16'(i));
            end
        end else begin
            if (men[0]) begin
                if (mwe[0]) vram0[madr[0][11:0]] <= mwd[0];
                else        mrd[0] <= vram0[madr[0][11:0]];
            end
            if (men[1]) begin
                if (mwe[1]) vram1[madr[1][11:0]] <= mwd[1];
                else        mrd[1] <= vram1[madr[1][11:0]];
            end
        end
    end

    // ---------------- reference model ----------------
    int          ul [2] = '{6, 9};
    logic [17:0] mq [2][$];
    logic [1:0]  mmem [2][4096];
    bit          e_en [2], e_we [2], e_rv [2], e_p1 [2], e_ovf [2];
    logic [15:0] e_addr [2];
    logic [1:0]  e_wd [2], e_rd [2], e_p1d [2];
    int          e_drop [2], e_urg [2];
    logic        ack_seen [2];

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s[%0d]: got %0h, expected %0h at %0t", name, idx, act, exp, $time);
    endtask

    function automatic bit m_urgent(input int m);
        return (mq[m].size() > 0) && (mq[m].size() >= ul[m]);
    endfunction

    function automatic bit m_ack(input int m);
        return !rst && !m_urgent(m) && rd_req;
    endfunction

    task automatic model_step(input int m);
        bit          urg, wg, rg;
        logic [17:0] h;
        urg = m_urgent(m);
        if (rst) begin
            mq[m].delete();
            e_en[m] = 0; e_we[m] = 0; e_addr[m] = '0; e_wd[m] = '0;
            e_rv[m] = 0; e_rd[m] = '0; e_p1[m] = 0; e_ovf[m] = 0;
            e_drop[m] = 0; e_urg[m] = 0;
            return;
        end
        wg = (mq[m].size() > 0) && (urg || !rd_req);
        rg = !urg && rd_req;
        if (urg && e_urg[m] < 65535) e_urg[m]++;
        e_rv[m] = e_p1[m];
        e_rd[m] = e_p1[m] ? e_p1d[m] : 2'b00;
        e_p1[m] = rg;
        e_en[m] = wg || rg;
        e_we[m] = wg;
        if (wg) begin
            h = mq[m].pop_front();
            e_addr[m] = h[17:2];
            e_wd[m]   = h[1:0];
            mmem[m][h[13:2]] = h[1:0];
        end else if (rg) begin
            e_addr[m] = rd_addr;
            e_p1d[m]  = mmem[m][rd_addr[11:0]];
        end
        if (wr_valid) begin
            if (mq[m].size() < 8) mq[m].push_back({wr_addr, wr_data});
            else begin
                e_ovf[m] = 1;
                if (e_drop[m] < 65535) e_drop[m]++;
            end
        end
    endtask

    // Inputs are already applied; check rd_ack mid-cycle, advance, check registers.
    task automatic step();
        #1;
        for (int m = 0; m < 2; m++) begin
            ack_seen[m] = ack[m];
            chk("rd_ack", m, 32'(ack[m]), 32'(m_ack(m)));
        end
        @(posedge vramclk);
        for (int m = 0; m < 2; m++) model_step(m);
        #1;
        for (int m = 0; m < 2; m++) begin
            chk("mem_en",     m, 32'(men[m]),  32'(e_en[m]));
            chk("mem_we",     m, 32'(mwe[m]),  32'(e_we[m]));
            chk("mem_addr",   m, 32'(madr[m]), 32'(e_addr[m]));
            chk("mem_wdata",  m, 32'(mwd[m]),  32'(e_wd[m]));
            chk("rd_valid",   m, 32'(rv[m]),   32'(e_rv[m]));
            chk("rd_data",    m, 32'(rdat[m]), 32'(e_rd[m]));
            chk("fifo_level", m, 32'(lvl[m]),  32'(mq[m].size()));
            chk("overflow",   m, 32'(ovf[m]),  32'(e_ovf[m]));
`ifdef ARB_STATS_EN
            chk("drop_count",   m, 32'(dcnt[m]), 32'(e_drop[m]));
            chk("urgent_count", m, 32'(ucnt[m]), 32'(e_urg[m]));
`endif
        end
    endtask

    task automatic drive(input logic v, input logic [15:0] wa, input logic [1:0] wd,
                         input logic r, input logic [15:0] ra);
        wr_valid = v; wr_addr = wa; wr_data = wd; rd_req = r; rd_addr = ra;
    endtask

    // ---------------- directed vectors (instance 0) ----------------
    typedef struct packed {
        logic        wv;
        logic [15:0] wa;
        logic [1:0]  wd;
        logic        rr;
        logic [15:0] ra;
        logic [27:0] exp;   // {ack, en, we, addr, wdata, rv, rdata, level}
    } vec_t;

    function automatic vec_t mk(input logic wv, input logic [15:0] wa, input logic [1:0] wd,
                                input logic rr, input logic [15:0] ra, input logic a,
                                input logic en, input logic we, input logic [15:0] ad,
                                input logic [1:0] wdv, input logic v, input logic [1:0] rd,
                                input logic [3:0] lv);
        vec_t t;
        t.wv = wv; t.wa = wa; t.wd = wd; t.rr = rr; t.ra = ra;
        t.exp = {a, en, we, ad, wdv, v, rd, lv};
        return t;
    endfunction

    vec_t        tv [10];
    logic [27:0] got;
    logic [9:0]  ap0;

    initial begin
        tv[0] = mk(1, 16'h0102, 2'b11, 0, 16'h0000, 0, 0, 0, 16'h0000, 2'd0, 0, 2'd0, 4'd1);
        tv[1] = mk(1, 16'h0103, 2'b01, 0, 16'h0000, 0, 1, 1, 16'h0102, 2'd3, 0, 2'd0, 4'd1);
        tv[2] = mk(0, 16'h0000, 2'b00, 0, 16'h0000, 0, 1, 1, 16'h0103, 2'd1, 0, 2'd0, 4'd0);
        tv[3] = mk(0, 16'h0000, 2'b00, 0, 16'h0000, 0, 0, 0, 16'h0103, 2'd1, 0, 2'd0, 4'd0);
        tv[4] = mk(0, 16'h0000, 2'b00, 1, 16'h0A05, 1, 1, 0, 16'h0A05, 2'd1, 0, 2'd0, 4'd0);
        tv[5] = mk(0, 16'h0000, 2'b00, 0, 16'h0000, 0, 0, 0, 16'h0A05, 2'd1, 1, 2'd2, 4'd0);
        tv[6] = mk(0, 16'h0000, 2'b00, 1, 16'h0102, 1, 1, 0, 16'h0102, 2'd1, 0, 2'd0, 4'd0);
        tv[7] = mk(0, 16'h0000, 2'b00, 1, 16'h0103, 1, 1, 0, 16'h0103, 2'd1, 1, 2'd3, 4'd0);
        tv[8] = mk(0, 16'h0000, 2'b00, 0, 16'h0000, 0, 0, 0, 16'h0103, 2'd1, 1, 2'd1, 4'd0);
        tv[9] = mk(0, 16'h0000, 2'b00, 0, 16'h0000, 0, 0, 0, 16'h0103, 2'd1, 0, 2'd0, 4'd0);

        for (int m = 0; m < 2; m++)
            for (int i = 0; i < 4096; i++) mmem[m][i] = base(16'(i));

        // Reset with random inputs.
        mem_init = 1'b1;
        rst      = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive(1'($urandom), 16'($urandom), 2'($urandom), 1'($urandom), 16'($urandom));
            step();
            if (k == 1) mem_init = 1'b0;
        end
        rst = 1'b0;

        // Idle writes, read latency, pipelined reads.
        for (int i = 0; i < 10; i++) begin
            drive(tv[i].wv, tv[i].wa, tv[i].wd, tv[i].rr, tv[i].ra);
            step();
            got = {ack_seen[0], men[0], mwe[0], madr[0], mwd[0], rv[0], rdat[0], lvl[0]};
            chk("vec", i, 32'(got), 32'(tv[i].exp));
        end

        // Urgent override: reads win until level 6, then writes until below 6.
        ap0 = 10'b1000111111;
        for (int k = 0; k < 10; k++) begin
            drive(k < 8, 16'h0020 + 16'(k), 2'(k), 1'b1, 16'h0010);
            step();
            chk("urg_ack0", k, 32'(ack_seen[0]), 32'(ap0[k]));
            chk("urg_ack1", k, 32'(ack_seen[1]), 32'd1);
        end

        rst = 1'b1;
        drive(0, 16'h0, 2'd0, 0, 16'h0);
        step();
        rst = 1'b0;

        // Fill instance 1 to 8, then push+pop at full, then a dropped write.
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, 16'h0040 + 16'(k), 2'(k + 1), 1'b1, 16'h0011);
            step();
        end
        chk("full_level", 1, 32'(lvl[1]), 32'd8);
        drive(1'b1, 16'h0050, 2'd2, 1'b0, 16'h0011);
        step();
        chk("pushpop_level", 1, 32'(lvl[1]), 32'd8);
        chk("pushpop_ovf",   1, 32'(ovf[1]), 32'd0);
        drive(1'b1, 16'h0051, 2'd3, 1'b1, 16'h0012);
        step();
        chk("drop_ovf",   1, 32'(ovf[1]), 32'd1);
        chk("drop_level", 1, 32'(lvl[1]), 32'd8);
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 16'h0, 2'd0, 1'b1, 16'h0013);
            step();
            chk("ovf_sticky", k, 32'(ovf[1]), 32'd1);
        end
        rst = 1'b1;
        step();
        chk("ovf_clear", 1, 32'(ovf[1]), 32'd0);
        rst = 1'b0;

        // Randomized traffic; read requests held until instance 0 acks.
        drive(0, 16'h0, 2'd0, 0, 16'h0);
        for (int k = 0; k < 3000; k++) begin
            rst      = ($urandom_range(0, 299) == 0);
            wr_valid = ($urandom_range(0, 9) < 7);
            wr_addr  = 16'($urandom_range(0, 31));
            wr_data  = 2'($urandom);
            if (!rd_req || ack_seen[0]) begin
                rd_req  = ($urandom_range(0, 9) < 6);
                rd_addr = 16'($urandom_range(0, 31));
            end
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
